branch_predictor: RTL and testbench

// - Fetch-stage predictor driving the PC-select MUX_2X1 directly downstream.
//   - pred_taken drives Choose; pred_target drives In2; In1 is PC+4.
// - Direct-mapped table with a 2-bit saturating counter, tag and target per entry.
// - Tables are trained from EX on every resolved branch or jump.
// - EX flags mispredictions so the hazard logic can flush IF/ID.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_sat_counter2.sv | 26 ++
 rtl/branch_predictor.sv | 134 +++++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the fetch-stage branch predictor:
//   - ctr_t      : 2-bit saturating confidence counter
//   - CTR_*      : counter encodings (strong/weak not-taken, weak/strong taken)
//   - CTR_RESET  : counter value loaded by reset
//   - CTR_ALLOC  : counter value written when a taken branch allocates an entry
//   - ctr_predicts_taken() : direction implied by a counter value
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;  // strong not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weak not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weak taken
  localparam ctr_t CTR_ST  = 2'b11;  // strong taken

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // The upper counter bit alone carries the direction.
  function automatic logic ctr_predicts_taken(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Next-state function of a 2-bit saturating counter.
// Ports:
//   cur   in  2  current counter value
//   taken in  1  resolved outcome: 1 = count up, 0 = count down
//   nxt   out 2  next counter value, held at 00 / 11 at the extremes
// ---------------------------------------------------------------------------
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage direct-mapped branch predictor. Each entry holds a valid bit,
// a tag, a target and a 2-bit saturating counter. The lookup feeds the PC
// select mux (pred_taken -> Choose, pred_target -> In2, In1 = PC+4) in the
// same cycle as if_pc. EX trains the table on every resolved branch/jump and
// reports mispredictions so younger stages can be flushed.
//
// Ports:
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous active-low reset
//   if_pc          in   n  PC being fetched
//   pred_taken     out  1  redirect fetch to pred_target
//   pred_target    out  n  predicted target (0 on a miss)
//   ex_valid       in   1  EX holds a real instruction
//   ex_is_branch   in   1  EX instruction is a branch or jal/jalr
//   ex_pc          in   n  PC of the EX instruction
//   ex_taken       in   1  resolved direction
//   ex_target      in   n  resolved target
//   ex_pred_taken  in   1  direction predicted for this instruction
//   ex_pred_target in   n  target predicted for this instruction
//   ex_mispredict  out  1  flush younger stages, refetch from ex_redirect
//   ex_redirect    out  n  correct next PC (meaningful when ex_mispredict=1)
//
// Qualification: there is no backpressure. An EX slot is consumed in the
// cycle it is presented; it trains the table and may raise ex_mispredict
// only when ex_valid && ex_is_branch, otherwise all ex_* inputs are ignored.
// ---------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int n        = 32,
  parameter int IDX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] if_pc,
  output logic         pred_taken,
  output logic [n-1:0] pred_target,
  input  logic         ex_valid,
  input  logic         ex_is_branch,
  input  logic [n-1:0] ex_pc,
  input  logic         ex_taken,
  input  logic [n-1:0] ex_target,
  input  logic         ex_pred_taken,
  input  logic [n-1:0] ex_pred_target,
  output logic         ex_mispredict,
  output logic [n-1:0] ex_redirect
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = n - IDX_BITS - 2;

  // Table held in flops so the lookup can be purely combinational.
  logic             tbl_valid [ENTRIES];
  logic [TAG_W-1:0] tbl_tag   [ENTRIES];
  logic [n-1:0]     tbl_tgt   [ENTRIES];
  ctr_t             tbl_ctr   [ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup (fetch side)
  // -------------------------------------------------------------------------
  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]    if_tag;
  logic                if_hit;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[n-1:IDX_BITS+2];
  assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);

  assign pred_taken  = if_hit && ctr_predicts_taken(tbl_ctr[if_idx]);
  assign pred_target = if_hit ? tbl_tgt[if_idx] : '0;

  // Instruction-alignment bits never take part in the lookup.
  logic unused_if_pc_low;
  assign unused_if_pc_low = ^if_pc[1:0];

  // -------------------------------------------------------------------------
  // Resolve (EX side)
  // -------------------------------------------------------------------------
  logic ex_update;

  assign ex_update = ex_valid && ex_is_branch;

  // A taken prediction with the wrong target is as bad as a wrong direction;
  // a not-taken resolution never cares what target was predicted.
  assign ex_mispredict = ex_update &&
                         ((ex_pred_taken != ex_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));
  assign ex_redirect   = ex_taken ? ex_target : (ex_pc + n'(4));

  // -------------------------------------------------------------------------
  // Training
  // -------------------------------------------------------------------------
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]    ex_tag;
  logic                ex_hit;
  logic [1:0]          ex_ctr_nxt;

  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[n-1:IDX_BITS+2];
  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

  sat_counter2 u_sat_counter2 (
    .cur   (tbl_ctr[ex_idx]),
    .taken (ex_taken),
    .nxt   (ex_ctr_nxt)
  );

  // Writes land at the clock edge only, so a lookup of the index being
  // trained in the same cycle still sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_tag[i]   <= '0;
        tbl_tgt[i]   <= '0;
        tbl_ctr[i]   <= CTR_RESET;
      end
    end else if (ex_update) begin
      if (ex_hit) begin
        tbl_ctr[ex_idx] <= ex_ctr_nxt;
        if (ex_taken) tbl_tgt[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        // Taken miss replaces whatever lived at this index (aliasing).
        tbl_valid[ex_idx] <= 1'b1;
        tbl_tag[ex_idx]   <= ex_tag;
        tbl_tgt[ex_idx]   <= ex_target;
        tbl_ctr[ex_idx]   <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] ex_redirect;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.n(32), .IDX_BITS(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect    (ex_redirect)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Reference model: a 16-entry table described by plain integers.
  // Confidence is a number 0..3; 2 or more means "predict taken".
  // ---------------------------------------------------------------------
  logic        m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      t  = (m_ctr[i] >= 2);
      tg = m_tgt[i];
    end else begin
      t  = 1'b0;
      tg = 32'h0;
    end
  endtask

  task automatic m_train(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (t) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tg;
      m_ctr[i]   = 2;
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard check
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks. All are entered just after a falling edge.
  // ---------------------------------------------------------------------
  task automatic ex_idle();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  // One cycle: drive, check combinational outputs against the model,
  // clock, then let the model absorb the training event.
  task automatic step(input logic [31:0] ipc, input logic ev, input logic eb,
                      input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                      input logic ept, input logic [31:0] eptg);
    logic        exp_t;
    logic [31:0] exp_tg;
    logic        exp_mis;
    if_pc          = ipc;
    ex_valid       = ev;
    ex_is_branch   = eb;
    ex_pc          = epc;
    ex_taken       = et;
    ex_target      = etgt;
    ex_pred_taken  = ept;
    ex_pred_target = eptg;
    #1;
    m_predict(ipc, exp_t, exp_tg);
    check("pred_taken", {31'b0, pred_taken}, {31'b0, exp_t});
    check("pred_target", pred_target, exp_tg);
    exp_mis = ev && eb && ((ept != et) || (et && (eptg != etgt)));
    check("ex_mispredict", {31'b0, ex_mispredict}, {31'b0, exp_mis});
    if (exp_mis) check("ex_redirect", ex_redirect, et ? etgt : epc + 32'd4);
    @(posedge clk);
    if (ev && eb) m_train(epc, et, etgt);
    @(negedge clk);
  endtask

  // Resolve a branch at pc, carrying the prediction fetch would have made.
  task automatic branch(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    logic        pt;
    logic [31:0] ptg;
    m_predict(pc, pt, ptg);
    step(pc, 1'b1, 1'b1, pc, t, tg, pt, ptg);
  endtask

  // Directed lookup against hand-derived constants; no clock edge.
  task automatic expect_pred(input logic [31:0] ipc, input logic t, input logic [31:0] tg);
    ex_idle();
    if_pc = ipc;
    #1;
    check("exp_pred_taken", {31'b0, pred_taken}, {31'b0, t});
    check("exp_pred_target", pred_target, tg);
  endtask

  // Asynchronous reset pulse, entered mid-cycle; outputs must clear at once.
  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("rst_pred_target", pred_target, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] r_ipc, r_epc, r_tgt, r_ptg;
    logic        r_ev, r_eb, r_et, r_pt;

    rst_n = 1'b0;
    if_pc = 32'h100;
    ex_idle();
    m_reset();
    @(negedge clk);
    reset_dut();

    // cold lookup after reset
    expect_pred(32'h100, 1'b0, 32'h0);

    // first taken resolve allocates weak-taken
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    expect_pred(32'h100, 1'b1, 32'h40);

    // saturate at strong taken, then walk back down
    repeat (3) branch(32'h100, 1'b1, 32'h40);
    branch(32'h100, 1'b0, 32'h40);
    expect_pred(32'h100, 1'b1, 32'h40);
    branch(32'h100, 1'b0, 32'h40);
    expect_pred(32'h100, 1'b0, 32'h40);

    // aliasing: 0x140 shares index 0 with 0x100
    expect_pred(32'h140, 1'b0, 32'h0);
    branch(32'h140, 1'b1, 32'h200);
    expect_pred(32'h140, 1'b1, 32'h200);
    expect_pred(32'h100, 1'b0, 32'h0);
    branch(32'h140, 1'b0, 32'h200);
    expect_pred(32'h140, 1'b0, 32'h200);

    // mid-run reset clears a live taken entry without a clock edge
    branch(32'h100, 1'b1, 32'h40);
    expect_pred(32'h100, 1'b1, 32'h40);
    reset_dut();
    expect_pred(32'h100, 1'b0, 32'h0);

    // same-cycle lookup and update of cold idx 0: miss now, hit next cycle
    step(32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_pred(32'h0, 1'b1, 32'h80);

    // jump target change
    branch(32'h100, 1'b1, 32'h40);
    expect_pred(32'h100, 1'b1, 32'h40);
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
    expect_pred(32'h100, 1'b1, 32'h80);

    // not-taken, bubble and non-branch slots leave the table alone
    step(32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
    step(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
    step(32'h104, 1'b1, 1'b1, 32'h104, 1'b0, 32'h300, 1'b1, 32'h300);
    expect_pred(32'h100, 1'b1, 32'h80);
    expect_pred(32'h104, 1'b0, 32'h0);

    // reset held across an edge carrying a valid update: update is lost
    if_pc          = 32'h180;
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = 32'h180;
    ex_taken       = 1'b1;
    ex_target      = 32'h300;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    reset_dut();
    expect_pred(32'h180, 1'b0, 32'h0);
    expect_pred(32'h100, 1'b0, 32'h0);

    // randomized traffic over a small aliasing PC pool
    for (int k = 0; k < 500; k++) begin
      r_ipc = 32'h400 + 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 15)) * 4
              + 32'($urandom_range(0, 3));
      r_epc = 32'h400 + 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 15)) * 4
              + 32'($urandom_range(0, 3));
      r_ev  = ($urandom_range(0, 9) != 0);
      r_eb  = ($urandom_range(0, 9) < 7);
      r_et  = 1'($urandom_range(0, 1));
      r_tgt = 32'h2000 + 32'($urandom_range(0, 3)) * 16;
      if ($urandom_range(0, 1) == 1) begin
        m_predict(r_epc, r_pt, r_ptg);
      end else begin
        r_pt  = 1'($urandom_range(0, 1));
        r_ptg = 32'h2000 + 32'($urandom_range(0, 3)) * 16;
      end
      step(r_ipc, r_ev, r_eb, r_epc, r_et, r_tgt, r_pt, r_ptg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
